reg_wb_scoreboard: RTL and testbench
====================================

Name: reg_wb_scoreboard

Overview:
- Sits between the issue stage, the two writeback units (integer ALU on wb0, FPU/memory on wb1) and the 32-entry register file.
- Tracks pending writes with one busy bit per register and stalls issue on RAW/WAW hazards.
- Arbitrates the two writeback sources onto the single register-file write path, driving the per-register one-hot enables and the shared write data.
- r0 is hardwired zero; r1–r15 are integer and r16–r31 are float. Both banks are handled uniformly.

Parameters:
- NREG, 32, number of architectural registers. Fixed at 32 in this design; index width is 5.
- DW, 32, register data width.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- issue_valid  in  1  instruction presented for issue
- issue_ready  out  1  issue accepted this cycle when issue_valid is also high
- issue_rs1  in  5  source register 1
- issue_rs2  in  5  source register 2
- issue_rd  in  5  destination register
- issue_has_rd  in  1  instruction writes issue_rd
- wb0_valid  in  1  ALU writeback request
- wb0_ready  out  1  wb0 granted
- wb0_rd  in  5  wb0 destination register
- wb0_data  in  DW  wb0 data
- wb1_valid, wb1_ready, wb1_rd, wb1_data: same as the wb0 signals, for FPU/memory
- reg_enable  out  32  one-hot write enables to the register file; bit 0 never set
- reg_wdata  out  DW  write data broadcast to all register inputs
- busy  out  32  current busy bits
- wb_err  out  1  sticky: writeback to a register that was not busy
- stall_cnt  out  32  issue stall cycle count (see Optional Feature)

Behaviour:
- Reset (rstn low, asynchronous): busy=0, reg_enable=0, reg_wdata=0, wb_err=0, rr_ptr=0, stall_cnt=0.
- Hazard detection:
  - issue_ready = !busy[rs1] && !busy[rs2] && !(issue_has_rd && busy[rd]).
  - Uses registered busy bits only; there is no same-cycle bypass.
  - busy[0] is always 0.
- Issue: on issue_valid && issue_ready && issue_has_rd && rd!=0, busy[rd] is set at the next edge.
- Arbitration is combinational within a cycle:
  - Only one valid: that port is granted.
  - Both valid: the port selected by rr_ptr is granted. rr_ptr=0 favours wb0.
  - After a contested grant, rr_ptr points to the other port. rr_ptr is unchanged on uncontested grants.
  - wbX_ready is high only for the granted port. The loser holds valid, rd and data stable until granted.
- Write stage:
  - The grant in cycle N registers reg_enable=onehot(rd) and reg_wdata=data at edge N+1.
  - Both are held for exactly one cycle, then reg_enable returns to 0.
  - The register file captures the data at edge N+2.
- Busy clear: busy[rd] is cleared at edge N+2, the same edge the register file writes. An instruction reading rd can therefore issue in cycle N+2 and sees the new value.
- Writeback to rd=0: the port is granted, reg_enable stays 0, and no error is raised.
- Writeback to a non-busy rd!=0: the write is still performed and wb_err is set. wb_err clears only on reset.
- Set/clear on the same edge for the same register: set wins.
  - WAW stalling makes this unreachable in normal use.
  - The bench forces it by writeback without issue.
- Throughput: one writeback per cycle sustained. The write stage is pipelined, so back-to-back grants produce back-to-back enables.
- Reset mid-operation: all pending writes are dropped, busy is cleared, and any in-flight write stage is discarded (reg_enable forced to 0).

Optional Feature:
- Macro: SB_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 every cycle with issue_valid && !issue_ready. It saturates at 0xFFFFFFFF and resets to 0.
- Undefined: the counter logic is absent and stall_cnt is tied to 0.

Test Plan:
- Issue rd=5 (has_rd=1) -> busy[5]=1 next cycle. Issue rs1=5 -> issue_ready=0. wb0 rd=5 data=0xDEADBEEF granted in cycle N -> reg_enable=0x00000020 and reg_wdata=0xDEADBEEF in cycle N+1; busy[5]=0 and issue_ready=1 in cycle N+2.
- wb0 (rd=3) and wb1 (rd=17) valid together for two cycles from reset -> first wb0_ready=1 and reg_enable=0x8; then wb1_ready=1 and reg_enable=0x00020000. The next contested cycle grants wb0 again.
- wb1 rd=0 data=0x1234 -> wb1_ready=1, reg_enable stays 0, wb_err stays 0.
- wb0 rd=9 with busy[9]=0 -> reg_enable=0x200 and wb_err=1, which remains 1 until rstn is asserted.
- Issue rd=20, then drop rstn asynchronously mid-cycle while wb1 rd=20 is in the write stage -> busy=0, reg_enable=0 immediately, no write.
- With SB_STALL_CNT_EN: hold issue_valid=1 on a busy rs2 for 7 cycles -> stall_cnt=7. Without the macro -> stall_cnt=0.

Source files
------------

// File: rtl/reg_wb_scoreboard_if.sv
// Issue and writeback handshake bundle for reg_wb_scoreboard.
// master = issue stage / writeback units, slave = scoreboard.
interface reg_wb_scoreboard_if #(parameter int DW = 32);
    logic          issue_valid;
    logic          issue_ready;
    logic [4:0]    issue_rs1;
    logic [4:0]    issue_rs2;
    logic [4:0]    issue_rd;
    logic          issue_has_rd;
    logic          wb0_valid;
    logic          wb0_ready;
    logic [4:0]    wb0_rd;
    logic [DW-1:0] wb0_data;
    logic          wb1_valid;
    logic          wb1_ready;
    logic [4:0]    wb1_rd;
    logic [DW-1:0] wb1_data;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_has_rd,
        output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
        input  issue_ready, wb0_ready, wb1_ready
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_has_rd,
        input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
        output issue_ready, wb0_ready, wb1_ready
    );
endinterface

// File: rtl/reg_wb_scoreboard.sv
// Register busy-bit scoreboard with two-source round-robin writeback arbiter.
// Optional SB_STALL_CNT_EN adds a saturating issue-stall cycle counter.
module reg_wb_scoreboard #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic                clk,
    input  logic                rstn,
    reg_wb_scoreboard_if.slave  sb,
    output logic [NREG-1:0]     reg_enable,
    output logic [DW-1:0]       reg_wdata,
    output logic [NREG-1:0]     busy,
    output logic                wb_err,
    output logic [31:0]         stall_cnt
);
    localparam int IW = $clog2(NREG);

    logic            rr_ptr;
    logic            issue_ok;
    logic            contested;
    logic            gnt0, gnt1, gnt_any;
    logic [IW-1:0]   gnt_rd;
    logic [DW-1:0]   gnt_data;
    logic [NREG-1:0] gnt_onehot;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] busy_nxt;

    always_comb begin
        issue_ok   = !busy[sb.issue_rs1] && !busy[sb.issue_rs2] &&
                     !(sb.issue_has_rd && busy[sb.issue_rd]);
        contested  = sb.wb0_valid && sb.wb1_valid;
        gnt0       = sb.wb0_valid && (!sb.wb1_valid || !rr_ptr);
        gnt1       = sb.wb1_valid && !gnt0;
        gnt_any    = gnt0 || gnt1;
        gnt_rd     = gnt1 ? sb.wb1_rd   : sb.wb0_rd;
        gnt_data   = gnt1 ? sb.wb1_data : sb.wb0_data;
        gnt_onehot = '0;
        if (gnt_any && gnt_rd != '0)
            gnt_onehot[gnt_rd] = 1'b1;
        set_mask = '0;
        if (sb.issue_valid && issue_ok && sb.issue_has_rd && sb.issue_rd != '0)
            set_mask[sb.issue_rd] = 1'b1;
        // The write stage's enable doubles as the clear mask, so busy drops on
        // the same edge the register file captures; a new set still wins.
        busy_nxt    = (busy & ~reg_enable) | set_mask;
        busy_nxt[0] = 1'b0;
    end

    assign sb.issue_ready = issue_ok;
    assign sb.wb0_ready   = gnt0;
    assign sb.wb1_ready   = gnt1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy       <= '0;
            reg_enable <= '0;
            reg_wdata  <= '0;
            wb_err     <= 1'b0;
            rr_ptr     <= 1'b0;
        end else begin
            busy       <= busy_nxt;
            reg_enable <= gnt_onehot;
            if (gnt_any)
                reg_wdata <= gnt_data;
            if (contested)
                rr_ptr <= ~rr_ptr;
            if (gnt_any && gnt_rd != '0 && !busy[gnt_rd])
                wb_err <= 1'b1;
        end
    end

`ifdef SB_STALL_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            stall_cnt <= '0;
        else if (sb.issue_valid && !issue_ok && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_reg_wb_scoreboard.sv
// Randomized + directed bench for reg_wb_scoreboard against a cycle-level
// reference model built from busy sets and a pending-write record.
module tb_reg_wb_scoreboard;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] reg_enable, reg_wdata, busy, stall_cnt;
    logic        wb_err;

    reg_wb_scoreboard_if #(.DW(32)) sb ();

    reg_wb_scoreboard #(.NREG(32), .DW(32)) dut (
        .clk(clk), .rstn(rstn), .sb(sb),
        .reg_enable(reg_enable), .reg_wdata(reg_wdata), .busy(busy),
        .wb_err(wb_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [31:0] mbusy, men, mwd, mstall;
    logic        merr, mrr;
    int          last_g;
    logic        obs_r0, obs_r1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        sb.issue_valid = 0; sb.issue_rs1 = 0; sb.issue_rs2 = 0;
        sb.issue_rd = 0; sb.issue_has_rd = 0;
        sb.wb0_valid = 0; sb.wb0_rd = 0; sb.wb0_data = 0;
        sb.wb1_valid = 0; sb.wb1_rd = 0; sb.wb1_data = 0;
    endtask

    task automatic model_reset();
        mbusy = 0; men = 0; mwd = 0; mstall = 0; merr = 0; mrr = 0;
    endtask

    // one clock cycle: inputs already driven just after the previous edge
    task automatic cyc();
        logic        er, nerr, nrr;
        logic [31:0] nb, nen, nwd;
        logic [4:0]  grd;
        int          g;
        #1;
        er = !mbusy[sb.issue_rs1] && !mbusy[sb.issue_rs2] &&
             !(sb.issue_has_rd && mbusy[sb.issue_rd]);
        chk("issue_ready", {31'd0, sb.issue_ready}, {31'd0, er});
        g = -1;
        if (sb.wb0_valid && sb.wb1_valid) g = mrr ? 1 : 0;
        else if (sb.wb0_valid)            g = 0;
        else if (sb.wb1_valid)            g = 1;
        obs_r0 = sb.wb0_ready;
        obs_r1 = sb.wb1_ready;
        chk("wb0_ready", {31'd0, obs_r0}, {31'd0, g == 0});
        chk("wb1_ready", {31'd0, obs_r1}, {31'd0, g == 1});
        last_g = g;
        nb = mbusy & ~men;
        if (sb.issue_valid && er && sb.issue_has_rd && sb.issue_rd != 0)
            nb[sb.issue_rd] = 1'b1;
        nb[0] = 1'b0;
        nen = 0; nwd = mwd; nerr = merr; nrr = mrr;
        if (g >= 0) begin
            grd = (g == 1) ? sb.wb1_rd : sb.wb0_rd;
            nwd = (g == 1) ? sb.wb1_data : sb.wb0_data;
            if (grd != 0) begin
                nen[grd] = 1'b1;
                if (!mbusy[grd]) nerr = 1'b1;
            end
            if (sb.wb0_valid && sb.wb1_valid) nrr = !mrr;
        end
`ifdef SB_STALL_CNT_EN
        if (sb.issue_valid && !er && mstall != 32'hFFFF_FFFF) mstall = mstall + 1;
`endif
        @(posedge clk);
        #1;
        mbusy = nb; men = nen; mwd = nwd; merr = nerr; mrr = nrr;
        chk("busy", busy, mbusy);
        chk("reg_enable", reg_enable, men);
        if (men != 0) chk("reg_wdata", reg_wdata, mwd);
        chk("wb_err", {31'd0, wb_err}, {31'd0, merr});
        chk("stall_cnt", stall_cnt, mstall);
    endtask

    // called just after an edge: async reset mid-cycle, then release
    task automatic do_reset();
        #1 rstn = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_en", reg_enable, 0);
        chk("rst_err", {31'd0, wb_err}, 0);
        chk("rst_stall", stall_cnt, 0);
        model_reset();
        idle();
        @(negedge clk) rstn = 1;
        @(posedge clk);
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_en", reg_enable, 0);
    endtask

    // writeback target: a busy reg not claimed elsewhere, or occasionally r0
    function automatic int pick(input int other);
        int q[$];
        if ($urandom % 8 == 0) return 0;
        for (int i = 1; i < 32; i++)
            if (mbusy[i] && !men[i] && i != other) q.push_back(i);
        if (q.size() == 0) return -1;
        return q[$urandom % q.size()];
    endfunction

    initial begin
        int r;
        model_reset();
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_en", reg_enable, 0);
        chk("reset_wdata", reg_wdata, 0);
        chk("reset_err", {31'd0, wb_err}, 0);
        chk("reset_stall", stall_cnt, 0);
        @(negedge clk) rstn = 1;
        @(posedge clk);
        #1;

        // randomized traffic, loser ports hold their request until granted
        for (int c = 0; c < 400; c++) begin
            sb.issue_valid  = $urandom % 2;
            sb.issue_rs1    = 5'($urandom);
            sb.issue_rs2    = 5'($urandom);
            sb.issue_rd     = 5'($urandom);
            sb.issue_has_rd = ($urandom % 4) != 0;
            if (!sb.wb0_valid && $urandom % 2) begin
                r = pick(sb.wb1_valid ? int'(sb.wb1_rd) : -1);
                if (r >= 0) begin
                    sb.wb0_valid = 1; sb.wb0_rd = 5'(r); sb.wb0_data = $urandom;
                end
            end
            if (!sb.wb1_valid && $urandom % 2) begin
                r = pick(sb.wb0_valid ? int'(sb.wb0_rd) : -1);
                if (r >= 0) begin
                    sb.wb1_valid = 1; sb.wb1_rd = 5'(r); sb.wb1_data = $urandom;
                end
            end
            cyc();
            if (last_g == 0) sb.wb0_valid = 0;
            if (last_g == 1) sb.wb1_valid = 0;
        end

        // r0 writeback: granted, no enable, no error
        do_reset();
        sb.wb1_valid = 1; sb.wb1_rd = 0; sb.wb1_data = 32'h1234;
        cyc();
        chk("r0_ready", {31'd0, obs_r1}, 1);
        sb.wb1_valid = 0;
        chk("r0_en", reg_enable, 0);
        cyc();
        chk("r0_err", {31'd0, wb_err}, 0);

        // issue rd=5, RAW stall, writeback, release
        sb.issue_valid = 1; sb.issue_rd = 5; sb.issue_has_rd = 1;
        cyc();
        chk("t1_busy5", {31'd0, busy[5]}, 1);
        sb.issue_has_rd = 0; sb.issue_rs1 = 5;
        #1 chk("t1_stall", {31'd0, sb.issue_ready}, 0);
        cyc();
        sb.issue_valid = 0;
        sb.wb0_valid = 1; sb.wb0_rd = 5; sb.wb0_data = 32'hDEADBEEF;
        cyc();
        sb.wb0_valid = 0;
        chk("t1_en", reg_enable, 32'h20);
        chk("t1_wdata", reg_wdata, 32'hDEADBEEF);
        cyc();
        chk("t1_busy5_clr", {31'd0, busy[5]}, 0);
        chk("t1_en_off", reg_enable, 0);
        sb.issue_valid = 1; sb.issue_rs1 = 5;
        #1 chk("t1_ready", {31'd0, sb.issue_ready}, 1);
        cyc();
        idle();

        // contested arbitration from reset
        do_reset();
        sb.wb0_valid = 1; sb.wb0_rd = 3;  sb.wb0_data = 32'hA0A0;
        sb.wb1_valid = 1; sb.wb1_rd = 17; sb.wb1_data = 32'hB1B1;
        cyc();
        chk("arb1_w0", {31'd0, obs_r0}, 1);
        chk("arb1_en", reg_enable, 32'h8);
        cyc();
        chk("arb2_w1", {31'd0, obs_r1}, 1);
        chk("arb2_en", reg_enable, 32'h0002_0000);
        sb.wb1_rd = 18;
        cyc();
        chk("arb3_w0", {31'd0, obs_r0}, 1);
        idle();
        cyc();

        // writeback to non-busy reg, then set-vs-clear on the same edge
        do_reset();
        sb.wb0_valid = 1; sb.wb0_rd = 9; sb.wb0_data = 32'h99;
        cyc();
        sb.wb0_valid = 0;
        chk("err_en", reg_enable, 32'h200);
        chk("err_set", {31'd0, wb_err}, 1);
        sb.wb0_valid = 1; sb.wb0_rd = 12; sb.wb0_data = 32'hC;
        cyc();
        sb.wb0_valid = 0;
        sb.issue_valid = 1; sb.issue_rd = 12; sb.issue_has_rd = 1;
        cyc();
        idle();
        chk("setwins_busy12", {31'd0, busy[12]}, 1);
        repeat (3) cyc();
        chk("err_sticky", {31'd0, wb_err}, 1);

        // async reset while a write is in the write stage
        do_reset();
        sb.issue_valid = 1; sb.issue_rd = 20; sb.issue_has_rd = 1;
        cyc();
        idle();
        sb.wb1_valid = 1; sb.wb1_rd = 20; sb.wb1_data = 32'h2020;
        cyc();
        chk("mid_en", reg_enable, 32'h0010_0000);
        do_reset();
        chk("mid_err", {31'd0, wb_err}, 0);

        // stall counter: 7 cycles blocked on busy rs2
        sb.issue_valid = 1; sb.issue_rd = 7; sb.issue_has_rd = 1;
        cyc();
        sb.issue_has_rd = 0; sb.issue_rs2 = 7;
        repeat (7) cyc();
`ifdef SB_STALL_CNT_EN
        chk("stall7", stall_cnt, 7);
`else
        chk("stall7", stall_cnt, 0);
`endif
        idle();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
